// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream memory loader.
package mem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs a strobed byte stream little-endian into one DATA_WIDTH word.
module word_packer
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     din,
  input  logic                  strobe,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  last_byte
);

  localparam int BYTES = DATA_WIDTH / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0] idx;

  assign last_byte = (idx == IDX_W'(BYTES - 1));

  // Index wraps to lane 0 after the last byte so the next word starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (strobe) begin
      idx <= last_byte ? '0 : idx + IDX_W'(1);
      for (int k = 0; k < BYTES; k++) begin
        if (idx == IDX_W'(k)) word[k*BYTE_W +: BYTE_W] <= din;
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Fills a synchronous RAM write port from a valid/ready byte stream, one transfer per start.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done
);

  generate
    if (DATA_WIDTH % BYTE_W != 0 || DATA_WIDTH < BYTE_W) begin : g_bad_width
      $error("mem_loader: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  state_t                state;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  hs;
  logic                  last_byte;
  logic                  pk_clear;

  // Every output is a pure decode of registered state.
  assign in_ready = (state == ST_COLLECT);
  assign we       = (state == ST_WRITE);
  assign done     = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);

  assign hs       = in_valid & in_ready & ~abort;
  assign pk_clear = abort | (state == ST_IDLE);

  word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .din       (in_data),
    .strobe    (hs),
    .clear     (pk_clear),
    .word      (wdata),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      waddr     <= '0;
      remaining <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_COLLECT;
              waddr     <= base_addr;
              remaining <= len;
            end
          end
        end
        ST_COLLECT: begin
          if (hs && last_byte) state <= ST_WRITE;
        end
        ST_WRITE: begin
          remaining <= remaining - (ADDR_WIDTH+1)'(1);
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            state <= ST_DONE;
          end else begin
            state <= ST_COLLECT;
            waddr <= waddr + ADDR_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus queues expected writes, a monitor checks them.
module tb_mem_loader;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, we, busy, done;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_done = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  wr_t exp_q[$];

  mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        last_we_cyc = cyc;
        chk("ready_in_write", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", waddr, wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("waddr", {24'd0, waddr}, {24'd0, e.addr});
          chk("wdata", {16'd0, wdata}, {16'd0, e.data});
        end
      end
      if (done) begin
        done_cyc = cyc;
        n_vec++;
        if (exp_done > 0) exp_done--;
        else begin
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input bit gap);
    foreach (bytes[i]) begin
      bit hs;
      int budget;
      in_valid = 1'b1; in_data = bytes[i];
      hs = 1'b0; budget = 0;
      while (!hs && budget < 50) begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!hs) begin
        n_vec++; n_err++;
        $display("FAIL byte_timeout: got no handshake expected accept of 0x%0h", bytes[i]);
      end
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_pending", exp_done, 32'd0);
  endtask

  initial begin
    logic [7:0] b[$];

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_waddr", {24'd0, waddr}, 32'd0);
    chk("rst_wdata", {16'd0, wdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two words, continuous stream, timing check
    exp_q.push_back('{addr: 8'h10, data: 16'h1234});
    exp_q.push_back('{addr: 8'h11, data: 16'h5678});
    exp_done++;
    do_start(8'h10, 9'd2);
    b = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_bytes(b, 1'b0);
    wait_idle();
    chk("start_to_last_we", last_we_cyc - start_cyc, 32'd6);
    chk("start_to_done", done_cyc - start_cyc, 32'd7);

    // Zero-length transfer
    exp_done++;
    do_start(8'h40, 9'd0);
    @(negedge clk);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("len0_done_clr", {31'd0, done}, 32'd0);
    chk("len0_busy_clr", {31'd0, busy}, 32'd0);
    wait_idle();

    // Address wrap
    exp_q.push_back('{addr: 8'hFF, data: 16'hBBAA});
    exp_q.push_back('{addr: 8'h00, data: 16'hDDCC});
    exp_done++;
    do_start(8'hFF, 9'd2);
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_bytes(b, 1'b0);
    wait_idle();

    // Gappy stream
    exp_q.push_back('{addr: 8'h20, data: 16'h1234});
    exp_q.push_back('{addr: 8'h21, data: 16'h5678});
    exp_done++;
    do_start(8'h20, 9'd2);
    b = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_bytes(b, 1'b1);
    wait_idle();

    // Abort after first byte of word 2, then immediate restart
    exp_q.push_back('{addr: 8'h30, data: 16'h2211});
    do_start(8'h30, 9'd2);
    b = '{8'h11, 8'h22, 8'h33};
    send_bytes(b, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back('{addr: 8'h50, data: 16'h5544});
    exp_done++;
    start = 1'b1; base_addr = 8'h50; len = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    b = '{8'h44, 8'h55};
    send_bytes(b, 1'b0);
    wait_idle();

    // Async reset mid-COLLECT
    do_start(8'h60, 9'd1);
    b = '{8'h99};
    send_bytes(b, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_we", {31'd0, we}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_waddr", {24'd0, waddr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_stay_idle", {31'd0, busy}, 32'd0);
    chk("arst_queue", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
